// File: rtl/prog_feeder.sv
// Program feeder: stores DEPTH 16-bit words, issues them one at a time to a CPU (Run/dataIn) and collects each result.
// Start-to-Run and done-to-next-Run latency is one cycle. Each word waits in WAIT until the CPU raises done.
// With FEEDER_TIMEOUT_EN defined, a WAIT that lasts TIMEOUT cycles aborts the program and sets the sticky err flag.
module prog_feeder #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  output logic          Run,
  output logic [15:0]   dataIn,
  input  logic          done,
  input  logic [15:0]   dataOut,
  output logic [15:0]   result,
  output logic          result_valid,
  output logic          busy,
  output logic          finished,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  if (DEPTH != 2**AW || TIMEOUT < 1) begin : g_cfg_check
    $error("prog_feeder: DEPTH must equal 2**AW and TIMEOUT must be positive");
  end

  state_t        state, state_nxt;
  logic [15:0]   mem [DEPTH];
  logic [AW:0]   ptr;
  logic [AW:0]   len;
  logic          ld_len;
  logic          inc_ptr;
  logic          capture;
  logic          tmo;

`ifdef FEEDER_TIMEOUT_EN
  localparam int            TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] wait_cnt;
  logic          err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // A done arriving on the final allowed cycle still wins over the abort.
  assign tmo = (state == WAIT) && !done && (wait_cnt == TLAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (state == IDLE && start) begin
      err_q <= 1'b0;
    end else if (tmo) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ld_len    = 1'b0;
    inc_ptr   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (prog_len != '0) begin
            ld_len    = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = FINISH;
          end
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (done) begin
          capture = 1'b1;
          if (ptr == len - ONE) begin
            state_nxt = FINISH;
          end else begin
            inc_ptr   = 1'b1;
            state_nxt = ISSUE;
          end
        end else if (tmo) begin
          state_nxt = FINISH;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr          <= '0;
      len          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= capture;
      if (ld_len) begin
        ptr <= '0;
        len <= prog_len;
      end else if (inc_ptr) begin
        ptr <= ptr + ONE;
      end
      if (capture) begin
        result <= dataOut;
      end
    end
  end

  // Program store is deliberately left out of reset so a program survives resetn.
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign Run      = (state == ISSUE);
  assign busy     = (state != IDLE);
  assign finished = (state == FINISH);
  assign dataIn   = (state == ISSUE || state == WAIT) ? mem[ptr[AW-1:0]] : 16'h0000;

endmodule

// File: tb/tb_prog_feeder.sv
// Directed bench for prog_feeder: drives and samples on the falling clock edge.
module tb_prog_feeder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          start;
  logic [AW:0]   prog_len;
  logic          Run;
  logic [15:0]   dataIn;
  logic          done;
  logic [15:0]   dataOut;
  logic [15:0]   result;
  logic          result_valid;
  logic          busy;
  logic          finished;
  logic          err;

  int checks = 0;
  int errors = 0;
  int cur_len = 0;
  int run_cnt = 0;
  int fin_cnt = 0;
  int rv_cnt  = 0;
  int run0, fin0, rv0;
  logic [15:0] exp_mem [DEPTH];

  prog_feeder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .prog_len(prog_len), .Run(Run), .dataIn(dataIn), .done(done),
    .dataOut(dataOut), .result(result), .result_valid(result_valid), .busy(busy),
    .finished(finished), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (Run === 1'b1) run_cnt++;
    if (finished === 1'b1) fin_cnt++;
    if (result_valid === 1'b1) rv_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input int a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    exp_mem[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic go(input int len);
    prog_len = (AW+1)'(len); start = 1'b1; cur_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the negedge where word 'first' is being issued.
  task automatic serve(input int first, input int last, input int dly, input logic [15:0] base);
    for (int i = first; i < last; i++) begin
      check("run_pulse", Run, 1);
      check("issue_word", dataIn, exp_mem[i]);
      repeat (dly) @(negedge clk);
      check("wait_run_low", Run, 0);
      check("wait_hold_word", dataIn, exp_mem[i]);
      done = 1'b1; dataOut = base + 16'(i);
      @(negedge clk);
      done = 1'b0;
      check("result_valid", result_valid, 1);
      check("result", result, base + 16'(i));
      if (i == cur_len - 1) check("finished", finished, 1);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_run"}, Run, 0);
    check({tag, "_fin"}, finished, 0);
    check({tag, "_rv"}, result_valid, 0);
  endtask

  initial begin
    resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; prog_len = '0; done = 1'b0; dataOut = '0;
    @(negedge clk);
    check_idle("reset");
    check("reset_result", result, 0);
    check("reset_dataIn", dataIn, 0);
    check("reset_err", err, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Three-word program, done three cycles into each WAIT
    write_word(0, 16'h3F1F);
    write_word(1, 16'h1F1F);
    write_word(2, 16'h5F1F);
    run0 = run_cnt; fin0 = fin_cnt; rv0 = rv_cnt;
    go(3);
    serve(0, 3, 3, 16'h00A0);
    @(negedge clk);
    check_idle("prog3_end");
    check("prog3_result_hold", result, 16'h00A2);
    check("prog3_runs", run_cnt - run0, 3);
    check("prog3_fins", fin_cnt - fin0, 1);
    check("prog3_rvs", rv_cnt - rv0, 3);

    // done while idle is ignored
    done = 1'b1; dataOut = 16'hFFFF;
    @(negedge clk);
    done = 1'b0;
    check_idle("idle_done");
    check("idle_done_result", result, 16'h00A2);

    // Zero-length program
    run0 = run_cnt;
    go(0);
    check("len0_fin", finished, 1);
    check("len0_busy", busy, 1);
    check("len0_run", Run, 0);
    @(negedge clk);
    check_idle("len0_end");
    check("len0_runs", run_cnt - run0, 0);

    // start and wr_en while busy are ignored
    go(3);
    check("busy_run", Run, 1);
    start = 1'b1; prog_len = 5'd1; wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'hBEEF;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    check("busy_wait_run", Run, 0);
    check("busy_wait_word", dataIn, exp_mem[0]);
    done = 1'b1; dataOut = 16'h0300;
    @(negedge clk);
    done = 1'b0;
    check("busy_rv", result_valid, 1);
    serve(1, 3, 2, 16'h0300);
    @(negedge clk);
    check_idle("busy_end");
    check("busy_result", result, 16'h0302);

    // Full-depth program, done on the first WAIT cycle
    for (int i = 0; i < DEPTH; i++) write_word(i, 16'h1000 + 16'(i * 16'h0111));
    run0 = run_cnt; fin0 = fin_cnt;
    go(16);
    serve(0, 16, 1, 16'h0200);
    @(negedge clk);
    check_idle("full_end");
    check("full_runs", run_cnt - run0, 16);
    check("full_fins", fin_cnt - fin0, 1);
    check("full_result", result, 16'h020F);

    // Reset during the second WAIT of a four-word program
    go(4);
    serve(0, 1, 1, 16'h0400);
    check("rst_run2", Run, 1);
    @(negedge clk);
    check("rst_in_wait", busy, 1);
    resetn = 1'b0;
    #1;
    check_idle("rst_mid");
    check("rst_mid_result", result, 0);
    check("rst_mid_dataIn", dataIn, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    go(4);
    serve(0, 4, 2, 16'h0500);
    @(negedge clk);
    check_idle("rst_rerun_end");
    check("rst_rerun_result", result, 16'h0503);
    check("err_default", err, 0);

`ifdef FEEDER_TIMEOUT_EN
    // CPU never answers: abort after 8 WAIT cycles
    rv0 = rv_cnt;
    go(1);
    check("to_run", Run, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("to_waiting", {busy, finished, Run}, 3'b100);
    end
    @(negedge clk);
    check("to_finished", finished, 1);
    check("to_err", err, 1);
    check("to_no_rv", rv_cnt - rv0, 0);
    @(negedge clk);
    check("to_err_sticky", err, 1);
    check("to_idle", busy, 0);
    go(1);
    check("to_err_clear", err, 0);
    serve(0, 1, 1, 16'h0600);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
